alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state type and default widths for alu_op_sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int DEF_OPERAND_SIZE = 16;
   localparam int DEF_ALU_OUT      = 32;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;
   localparam logic [1:0] ALU_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Command/response sequencer in front of a registered ALU.
//               Optional macro ALU_SEQ_DIVZERO_CHK_EN short-circuits DIV by 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
   parameter int ALU_OUT      = DEF_ALU_OUT
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OPERAND_SIZE-1:0] cmd_a,
   input  logic [OPERAND_SIZE-1:0] cmd_b,
   input  logic [1:0]              cmd_fun,
   output logic [OPERAND_SIZE-1:0] A,
   output logic [OPERAND_SIZE-1:0] B,
   output logic [1:0]              ALU_FUN,
   output logic                    Arith_Enable,
   input  logic [ALU_OUT-1:0]      Arith_out,
   input  logic                    Carry_OUT,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ALU_OUT-1:0]      rsp_data,
   output logic                    rsp_carry,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [15:0]             op_count
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_cmd_ready;
   logic                    w_arith_en;
   logic                    w_rsp_valid;
   logic                    w_accept;
   logic                    w_rsp_hs;
   logic                    w_divzero;
   logic [OPERAND_SIZE-1:0] r_a;
   logic [OPERAND_SIZE-1:0] r_b;
   logic [1:0]              r_fun;
   logic [ALU_OUT-1:0]      r_data;
   logic                    r_carry;
   logic [15:0]             r_op_count;

   assign w_accept = cmd_valid & w_cmd_ready;
   assign w_rsp_hs = w_rsp_valid & rsp_ready;

`ifdef ALU_SEQ_DIVZERO_CHK_EN
   logic r_err;
   assign w_divzero = (cmd_fun == ALU_DIV) && (cmd_b == '0);
   assign rsp_err   = r_err;
`else
   assign w_divzero = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_arith_en  = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = w_divzero ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_arith_en  = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_a        <= '0;
         r_b        <= '0;
         r_fun      <= ALU_ADD;
         r_data     <= '0;
         r_carry    <= 1'b0;
         r_op_count <= '0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
         r_err      <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            r_fun <= cmd_fun;
         end
         // The ALU result register is valid during WAIT; capture it verbatim.
         if (r_state == ST_WAIT) begin
            r_data  <= Arith_out;
            r_carry <= Carry_OUT;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
            r_err   <= 1'b0;
`endif
         end else if (w_accept && w_divzero) begin
            r_data  <= '0;
            r_carry <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
            r_err   <= 1'b1;
`endif
         end
         if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign cmd_ready    = w_cmd_ready;
   assign Arith_Enable = w_arith_en;
   assign rsp_valid    = w_rsp_valid;
   assign A            = r_a;
   assign B            = r_b;
   assign ALU_FUN      = r_fun;
   assign rsp_data     = r_data;
   assign rsp_carry    = r_carry;
   assign busy         = (r_state != ST_IDLE);
   assign op_count     = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with a registered ALU
//               model; honours ALU_SEQ_DIVZERO_CHK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int W = 16;
   localparam int R = 32;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
   localparam bit C_DIVCHK = 1'b1;
`else
   localparam bit C_DIVCHK = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic [1:0]   cmd_fun = 2'b00;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   ALU_FUN;
   logic         Arith_Enable;
   logic [R-1:0] Arith_out;
   logic         Carry_OUT;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [R-1:0] rsp_data;
   logic         rsp_carry;
   logic         rsp_err;
   logic         busy;
   logic [15:0]  op_count;

   int           total = 0;
   int           bad = 0;
   int           en_cnt = 0;
   logic [15:0]  exp_cnt = '0;
   bit           pre = 1'b0;

   alu_op_sequencer #(.OPERAND_SIZE(W), .ALU_OUT(R)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_Enable(Arith_Enable),
      .Arith_out(Arith_out), .Carry_OUT(Carry_OUT),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .busy(busy), .op_count(op_count)
   );

   always #5 CLK = ~CLK;

   // Bit R is the carry/borrow out of an R-bit result.
   function automatic logic [R:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] f);
      logic [R:0] ea;
      logic [R:0] eb;
      ea = {{(R+1-W){1'b0}}, a};
      eb = {{(R+1-W){1'b0}}, b};
      case (f)
         ALU_ADD: return ea + eb;
         ALU_SUB: return ea - eb;
         ALU_MUL: return ea * eb;
         default: return (b == '0) ? {1'b0, {R{1'b1}}} : ea / eb;
      endcase
   endfunction

   // Registered arithmetic unit: result is only meaningful the cycle after the strobe.
   always @(posedge CLK) begin
      if (Arith_Enable) begin
         {Carry_OUT, Arith_out} <= ref_alu(A, B, ALU_FUN);
      end else begin
         Arith_out <= $urandom;
         Carry_OUT <= 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (Arith_Enable === 1'b1) begin
         en_cnt++;
         chk("enable_excl", {cmd_ready, rsp_valid, busy}, 3'b001);
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                        input int dly, input bit hold,
                        output logic [R-1:0] got_d, output logic got_c);
      logic [R:0] exp_r;
      int         n;
      int         exp_lat;
      bit         unstable;
      logic       got_e;
      exp_r   = ref_alu(a, b, f);
      exp_lat = (C_DIVCHK && f == ALU_DIV && b == '0) ? 1 : 3;
      if (!pre) begin
         @(negedge CLK);
         cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_fun = f; en_cnt = 0;
         n = 0;
         while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
         end
         chk("cmd_ready_wait", cmd_ready, 1);
         @(negedge CLK);
      end
      pre       = 1'b0;
      cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 10) begin
         @(negedge CLK);
         n++;
      end
      chk("latency", n, exp_lat);
      got_d = rsp_data; got_c = rsp_carry; got_e = rsp_err;
      chk("rsp_data", got_d, (exp_lat == 1) ? '0 : exp_r[R-1:0]);
      chk("rsp_carry", got_c, (exp_lat == 1) ? 1'b0 : exp_r[R]);
      chk("rsp_err", got_e, exp_lat == 1);
      if (hold) begin
         cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h0042; cmd_fun = ALU_ADD;
      end
      unstable = 1'b0;
      for (int i = 0; i < dly; i++) begin
         @(negedge CLK);
         if (rsp_data !== got_d || rsp_carry !== got_c || rsp_err !== got_e ||
             rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || A !== a) unstable = 1'b1;
      end
      chk("rsp_hold", unstable, 0);
      chk("cmd_ready_resp", {busy, cmd_ready}, 2'b10);
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      if (exp_cnt != 16'hFFFF) exp_cnt++;
      chk("rsp_valid_done", rsp_valid, 0);
      chk("op_count", op_count, exp_cnt);
      chk("enable_pulses", en_cnt, (exp_lat == 3) ? 1 : 0);
      chk("retain_abf", {A, B, ALU_FUN}, {a, b, f});
      chk("cmd_ready_idle", cmd_ready, 1);
      if (hold) begin
         en_cnt = 0;
         pre    = 1'b1;
         @(negedge CLK);
         chk("accept_after_hs", {busy, A}, {1'b1, 16'h1234});
      end
   endtask

   initial begin
      logic [R-1:0] d;
      logic         c;
      bit           seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      repeat (3) @(negedge CLK);
      chk("rst_ctrl", {cmd_ready, rsp_valid, Arith_Enable, busy}, 4'b1000);
      chk("rst_rsp", {rsp_data, rsp_carry, rsp_err}, '0);
      chk("rst_abf", {A, B, ALU_FUN}, '0);
      chk("rst_count", op_count, 16'h0000);
      RST = 1'b1;
      @(negedge CLK);
      chk("ready_after_rst", cmd_ready, 1);

      // Abort an operation in WAIT.
      cmd_valid = 1'b1; cmd_a = 16'h00AA; cmd_b = 16'h0055; cmd_fun = ALU_MUL;
      @(negedge CLK);
      cmd_valid = 1'b0;
      @(negedge CLK);
      chk("wait_state", {busy, Arith_Enable, rsp_valid}, 3'b100);
      RST = 1'b0;
      @(negedge CLK);
      chk("abort_state", {Arith_Enable, rsp_valid, busy, cmd_ready}, 4'b0001);
      RST = 1'b1;
      @(negedge CLK);
      chk("ready_after_abort", cmd_ready, 1);
      seen = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         if (rsp_valid !== 1'b0 || Arith_Enable !== 1'b0) seen = 1'b1;
      end
      chk("no_resp_after_abort", seen, 0);
      chk("abort_count", op_count, exp_cnt);

      do_op(16'hFFFF, 16'h0001, ALU_ADD, 0, 1'b0, d, c);
      chk("add_data", d, 32'h0001_0000);
      chk("add_carry", c, 0);
      do_op(16'd3, 16'd5, ALU_SUB, 1, 1'b0, d, c);
      chk("sub_data", d, 32'hFFFF_FFFE);
      chk("sub_carry", c, 1);
      do_op(16'h00FF, 16'h0100, ALU_MUL, 0, 1'b0, d, c);
      chk("mul_data", d, 32'h0000_FF00);
      do_op(16'd100, 16'd7, ALU_DIV, 2, 1'b0, d, c);
      chk("div_data", d, 32'h0000_000E);
      do_op(16'h0050, 16'h0000, ALU_DIV, 0, 1'b0, d, c);
      chk("div0_data", d, C_DIVCHK ? 32'h0 : 32'hFFFF_FFFF);

      // Backpressure in RESP while the next command is already presented.
      do_op(16'h0010, 16'h0020, ALU_ADD, 5, 1'b1, d, c);
      chk("bp_data", d, 32'h0000_0030);
      do_op(16'h1234, 16'h0042, ALU_ADD, 0, 1'b0, d, c);
      chk("queued_data", d, 32'h0000_1276);

      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         do_op(ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0, d, c);
      end

      @(negedge CLK);
      dut.r_op_count = 16'hFFFE;
      exp_cnt        = 16'hFFFE;
      for (int k = 0; k < 3; k++) begin
         do_op(W'($urandom), W'($urandom_range(1, 255)), 2'($urandom_range(0, 3)), 0, 1'b0, d, c);
      end
      chk("op_count_sat", op_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
